// File: rtl/pipeline_pkg.sv
// Shared pipeline types: EX branch feedback, BTB entry layout, predictor FSM states.
package pipeline_pkg;

    localparam int         BTB_DEPTH_DEFAULT = 64;
    // Wide enough for the smallest legal table (4 entries); larger tables zero-fill the top bits.
    localparam int         BTB_TAG_W         = 28;
    localparam logic [1:0] CTR_WEAK_TAKEN    = 2'b10;

    typedef struct packed {
        logic [31:0] br_update_pc;
        logic        br_update_en;
        logic [31:0] br_pc_plus4;
        logic        br_valid;
        logic [31:0] br_target;
        logic        br_taken;
        logic        br_already_predicted;
    } branch_t;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bpu_state_e;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side feedback/redirect bundle between the pipeline and the predictor.
interface branch_predictor_if;

    logic [31:0]          i_if_pc;
    logic                 o_prd_taken;
    logic [31:0]          o_prd_pc;
    pipeline_pkg::branch_t i_alu_prd_pkg;
    logic                 o_redirect;
    logic [31:0]          o_redirect_pc;

    modport master (
        output i_if_pc,
        output i_alu_prd_pkg,
        input  o_prd_taken,
        input  o_prd_pc,
        input  o_redirect,
        input  o_redirect_pc
    );

    modport slave (
        input  i_if_pc,
        input  i_alu_prd_pkg,
        output o_prd_taken,
        output o_prd_pc,
        output o_redirect,
        output o_redirect_pc
    );

endinterface

// File: rtl/branch_predictor_btb_ram.sv
// BTB storage: register array with two combinational read ports (lookup, update compare) and one write port.
module btb_ram
    import pipeline_pkg::*;
#(
    parameter int DEPTH = BTB_DEPTH_DEFAULT,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  btb_entry_t       i_wdata,
    input  logic [IDX_W-1:0] i_lk_addr,
    output btb_entry_t       o_lk_data,
    input  logic [IDX_W-1:0] i_up_addr,
    output btb_entry_t       o_up_data
);

    btb_entry_t mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // No write-through: a read of the index being written returns the old entry.
    assign o_lk_data = mem_q[i_lk_addr];
    assign o_up_data = mem_q[i_up_addr];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit counters and EX misprediction redirect.
// Define BPU_PERF_CNT_EN to build the saturating branch / misprediction counters.
module branch_predictor
    import pipeline_pkg::*;
#(
    parameter int BTB_DEPTH = BTB_DEPTH_DEFAULT,
    parameter int IDX_W     = $clog2(BTB_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    branch_predictor_if.slave  bus,
    output logic               o_ready,
    output logic [31:0]        o_br_count,
    output logic [31:0]        o_mispred_count
);

    bpu_state_e       state_q;
    logic [IDX_W-1:0] init_idx_q;
    logic             ready_q;

    branch_t          fb;
    logic             in_run;
    logic             upd;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [BTB_TAG_W-1:0] lk_tag;
    logic [BTB_TAG_W-1:0] up_tag;
    btb_entry_t       lk_entry;
    btb_entry_t       up_entry;
    logic             lk_hit;
    logic             up_hit;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    btb_entry_t       ram_wdata;

    assign fb     = bus.i_alu_prd_pkg;
    assign in_run = (state_q == RUN);
    assign upd    = fb.br_valid & fb.br_update_en;

    assign lk_idx = bus.i_if_pc[IDX_W+1:2];
    assign lk_tag = BTB_TAG_W'(bus.i_if_pc >> (IDX_W + 2));
    assign up_idx = fb.br_update_pc[IDX_W+1:2];
    assign up_tag = BTB_TAG_W'(fb.br_update_pc >> (IDX_W + 2));

    btb_ram #(
        .DEPTH (BTB_DEPTH),
        .IDX_W (IDX_W)
    ) u_btb_ram (
        .i_clk     (i_clk),
        .i_we      (ram_we),
        .i_waddr   (ram_waddr),
        .i_wdata   (ram_wdata),
        .i_lk_addr (lk_idx),
        .o_lk_data (lk_entry),
        .i_up_addr (up_idx),
        .o_up_data (up_entry)
    );

    // Stale contents are ignored until every valid bit has been cleared.
    assign lk_hit = in_run & lk_entry.valid & (lk_entry.tag == lk_tag);
    assign up_hit = in_run & up_entry.valid & (up_entry.tag == up_tag);

    assign bus.o_prd_taken = lk_hit & lk_entry.ctr[1];
    assign bus.o_prd_pc    = bus.o_prd_taken ? lk_entry.target : bus.i_if_pc + 32'd4;

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = fb.br_pc_plus4;
        if (upd) begin
            if (fb.br_taken && !fb.br_already_predicted) begin
                redirect    = 1'b1;
                redirect_pc = fb.br_target;
            end else if (!fb.br_taken && fb.br_already_predicted) begin
                redirect    = 1'b1;
            end else if (fb.br_taken && fb.br_already_predicted &&
                         (!up_hit || up_entry.target != fb.br_target)) begin
                // Predicted taken but to the wrong place: JALR target moved or entry was evicted.
                redirect    = 1'b1;
                redirect_pc = fb.br_target;
            end
        end
    end

    assign bus.o_redirect    = redirect;
    assign bus.o_redirect_pc = redirect_pc;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = up_idx;
        ram_wdata = up_entry;
        if (!in_run) begin
            ram_we    = 1'b1;
            ram_waddr = init_idx_q;
            ram_wdata = '0;
        end else if (upd && i_rst_n) begin
            if (up_hit) begin
                ram_we        = 1'b1;
                ram_wdata.ctr = ctr_step(up_entry.ctr, fb.br_taken);
                if (fb.br_taken) begin
                    ram_wdata.target = fb.br_target;
                end
            end else if (fb.br_taken) begin
                ram_we           = 1'b1;
                ram_wdata.valid  = 1'b1;
                ram_wdata.tag    = up_tag;
                ram_wdata.target = fb.br_target;
                ram_wdata.ctr    = CTR_WEAK_TAKEN;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    init_idx_q <= init_idx_q + IDX_W'(1);
                    if (init_idx_q == IDX_W'(BTB_DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign o_ready = ready_q;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mis_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (in_run) begin
            if (upd && br_cnt_q != 32'hFFFF_FFFF) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (redirect && mis_cnt_q != 32'hFFFF_FFFF) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign o_br_count      = br_cnt_q;
    assign o_mispred_count = mis_cnt_q;
`else
    assign o_br_count      = 32'b0;
    assign o_mispred_count = 32'b0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations queued while driving, drained mid-cycle.
module tb_branch_predictor;
    import pipeline_pkg::*;

`ifdef BPU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int K_RED = 0, K_RPC = 1, K_PT = 2, K_PPC = 3, K_RDY = 4, K_BRC = 5, K_MSC = 6;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } sb_e;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_ready;
    logic [31:0] o_br_count;
    logic [31:0] o_mispred_count;

    branch_predictor_if bus();

    branch_predictor #(.BTB_DEPTH(64)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .bus             (bus),
        .o_ready         (o_ready),
        .o_br_count      (o_br_count),
        .o_mispred_count (o_mispred_count)
    );

    always #5 clk = ~clk;

    sb_e         sb[$];
    sb_e         e;
    logic [31:0] obs;
    int          n_checks = 0;
    int          n_err    = 0;
    int          exp_br   = 0;
    int          exp_mis  = 0;

    task automatic expect_val(input int kind, input logic [31:0] val, input string name);
        sb.push_back('{kind: kind, val: val, name: name});
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RED:   return {31'b0, bus.o_redirect};
            K_RPC:   return bus.o_redirect_pc;
            K_PT:    return {31'b0, bus.o_prd_taken};
            K_PPC:   return bus.o_prd_pc;
            K_RDY:   return {31'b0, o_ready};
            K_BRC:   return o_br_count;
            default: return o_mispred_count;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_upd();
        bus.i_alu_prd_pkg = '0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic vld, input logic en, input logic tk,
                             input logic [31:0] tgt, input logic ap, input logic exp_red,
                             input logic [31:0] exp_pc, input bit in_run);
        branch_t p;
        p.br_update_pc         = pc;
        p.br_update_en         = en;
        p.br_pc_plus4          = pc + 32'd4;
        p.br_valid             = vld;
        p.br_target            = tgt;
        p.br_taken             = tk;
        p.br_already_predicted = ap;
        bus.i_alu_prd_pkg      = p;
        expect_val(K_RED, {31'b0, exp_red}, "redirect");
        expect_val(K_RPC, exp_pc, "redirect_pc");
        if (in_run) begin
            if (vld && en) exp_br++;
            if (exp_red) exp_mis++;
        end
    endtask

    task automatic expect_lookup(input logic [31:0] pc, input logic taken, input logic [31:0] ppc);
        bus.i_if_pc = pc;
        expect_val(K_PT, {31'b0, taken}, "prd_taken");
        expect_val(K_PPC, ppc, "prd_pc");
    endtask

    task automatic expect_counters();
        expect_val(K_BRC, PERF ? exp_br : 32'd0, "br_count");
        expect_val(K_MSC, PERF ? exp_mis : 32'd0, "mispred_count");
    endtask

    task automatic test_reset();
        int          zeros;
        bit          done;
        logic [31:0] pc;
        rst_n = 1'b0;
        idle_upd();
        bus.i_if_pc = 32'h40;
        tick();
        tick();
        expect_lookup(32'h40, 1'b0, 32'h44);
        expect_val(K_RDY, 32'd0, "ready_in_reset");
        expect_counters();
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind); n_checks++;
            if (obs !== e.val) begin n_err++; $display("FAIL reset %s: got 0x%08h expected 0x%08h", e.name, obs, e.val); end
        end
        tick();
        rst_n = 1'b1;
        zeros = 0;
        done  = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            pc = (i == 3) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            expect_lookup(pc, 1'b0, pc + 32'd4);
            // Feedback during INIT still redirects but must not reach the table.
            if (i == 10) drive_upd(32'h100, 1'b1, 1'b1, 1'b1, 32'hA00, 1'b0, 1'b1, 32'hA00, 1'b0);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin n_err++; $display("FAIL init cyc%0d %s: got 0x%08h expected 0x%08h", i, e.name, obs, e.val); end
            end
            if (o_ready === 1'b1) done = 1'b1;
            else zeros++;
            tick();
            idle_upd();
        end
        n_checks++;
        if (!done || zeros != 64) begin
            n_err++;
            $display("FAIL init_length: ready low for %0d cycles (done=%0d) expected 64", zeros, done);
        end
    endtask

    task automatic test_allocate();
        expect_counters();
        expect_lookup(32'h100, 1'b0, 32'h104);
        drive_upd(32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind); n_checks++;
            if (obs !== e.val) begin n_err++; $display("FAIL alloc %s: got 0x%08h expected 0x%08h", e.name, obs, e.val); end
        end
        tick();
        idle_upd();
        expect_lookup(32'h100, 1'b1, 32'h200);
        expect_val(K_RED, 32'd0, "redirect_idle");
        expect_counters();
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind); n_checks++;
            if (obs !== e.val) begin n_err++; $display("FAIL alloc_predict %s: got 0x%08h expected 0x%08h", e.name, obs, e.val); end
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: drive_upd(32'h100, 1'b1, 1'b1, 1'b0, 32'h0BAD, 1'b1, 1'b1, 32'h104, 1'b1);
                1: begin
                    expect_lookup(32'h100, 1'b0, 32'h104);
                    drive_upd(32'h100, 1'b1, 1'b1, 1'b0, 32'h0BAD, 1'b0, 1'b0, 32'h104, 1'b1);
                end
                2: drive_upd(32'h100, 1'b1, 1'b1, 1'b0, 32'h0BAD, 1'b0, 1'b0, 32'h104, 1'b1);
                3: begin
                    expect_lookup(32'h100, 1'b0, 32'h104);
                    drive_upd(32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1);
                end
                default: begin
                    expect_lookup(32'h100, 1'b0, 32'h104);
                    expect_counters();
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin n_err++; $display("FAIL sat step%0d %s: got 0x%08h expected 0x%08h", s, e.name, obs, e.val); end
            end
            tick();
            idle_upd();
        end
    endtask

    task automatic test_jalr();
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: drive_upd(32'h304, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 1'b1, 32'h400, 1'b1);
                1: begin
                    expect_lookup(32'h304, 1'b1, 32'h400);
                    drive_upd(32'h304, 1'b1, 1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h308, 1'b1);
                end
                2: begin
                    expect_lookup(32'h304, 1'b1, 32'h400);
                    drive_upd(32'h304, 1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 1'b1, 32'h500, 1'b1);
                end
                3: begin
                    expect_lookup(32'h304, 1'b1, 32'h500);
                    drive_upd(32'h304, 1'b1, 1'b1, 1'b0, 32'h500, 1'b1, 1'b1, 32'h308, 1'b1);
                end
                default: begin
                    expect_lookup(32'h304, 1'b1, 32'h500);
                    expect_counters();
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin n_err++; $display("FAIL jalr step%0d %s: got 0x%08h expected 0x%08h", s, e.name, obs, e.val); end
            end
            tick();
            idle_upd();
        end
    endtask

    task automatic test_alias();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: drive_upd(32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1);
                1: begin
                    expect_lookup(32'h100, 1'b1, 32'h200);
                    drive_upd(32'h200, 1'b1, 1'b1, 1'b1, 32'h600, 1'b1, 1'b1, 32'h600, 1'b1);
                end
                2: expect_lookup(32'h100, 1'b0, 32'h104);
                default: begin
                    expect_lookup(32'h200, 1'b1, 32'h600);
                    expect_counters();
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin n_err++; $display("FAIL alias step%0d %s: got 0x%08h expected 0x%08h", s, e.name, obs, e.val); end
            end
            tick();
            idle_upd();
        end
    endtask

    task automatic test_gating();
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: drive_upd(32'h700, 1'b0, 1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 32'h704, 1'b1);
                1: begin
                    expect_lookup(32'h700, 1'b0, 32'h704);
                    drive_upd(32'h700, 1'b1, 1'b0, 1'b1, 32'h800, 1'b0, 1'b0, 32'h704, 1'b1);
                end
                default: begin
                    expect_lookup(32'h700, 1'b0, 32'h704);
                    expect_counters();
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin n_err++; $display("FAIL gating step%0d %s: got 0x%08h expected 0x%08h", s, e.name, obs, e.val); end
            end
            tick();
            idle_upd();
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: drive_upd(32'h708, 1'b1, 1'b1, 1'b1, 32'h900, 1'b0, 1'b1, 32'h900, 1'b1);
                1: begin
                    expect_lookup(32'h708, 1'b1, 32'h900);
                    drive_upd(32'h70C, 1'b1, 1'b1, 1'b1, 32'hA00, 1'b0, 1'b1, 32'hA00, 1'b1);
                end
                default: begin
                    expect_lookup(32'h70C, 1'b1, 32'hA00);
                    expect_counters();
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin n_err++; $display("FAIL b2b step%0d %s: got 0x%08h expected 0x%08h", s, e.name, obs, e.val); end
            end
            tick();
            idle_upd();
        end
    endtask

    task automatic test_midreset();
        int  waited;
        bit  done;
        rst_n = 1'b0;
        expect_counters();
        drive_upd(32'h800, 1'b1, 1'b1, 1'b1, 32'h900, 1'b0, 1'b1, 32'h900, 1'b0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind); n_checks++;
            if (obs !== e.val) begin n_err++; $display("FAIL midrst_drive %s: got 0x%08h expected 0x%08h", e.name, obs, e.val); end
        end
        tick();
        rst_n = 1'b1;
        idle_upd();
        exp_br  = 0;
        exp_mis = 0;
        expect_val(K_RDY, 32'd0, "ready_after_reset");
        expect_counters();
        expect_lookup(32'h708, 1'b0, 32'h70C);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind); n_checks++;
            if (obs !== e.val) begin n_err++; $display("FAIL midrst_init %s: got 0x%08h expected 0x%08h", e.name, obs, e.val); end
        end
        waited = 0;
        done   = 1'b0;
        while (!done && waited < 100) begin
            tick();
            waited++;
            if (o_ready === 1'b1) done = 1'b1;
        end
        n_checks++;
        if (!done || waited != 64) begin
            n_err++;
            $display("FAIL midrst_reinit: ready after %0d cycles (done=%0d) expected 64", waited, done);
        end
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: expect_lookup(32'h800, 1'b0, 32'h804);
                1: expect_lookup(32'h200, 1'b0, 32'h204);
                default: begin
                    expect_lookup(32'h70C, 1'b0, 32'h710);
                    expect_counters();
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin n_err++; $display("FAIL midrst_post step%0d %s: got 0x%08h expected 0x%08h", s, e.name, obs, e.val); end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_if_pc       = 32'h0;
        bus.i_alu_prd_pkg = '0;
        test_reset();
        test_allocate();
        test_saturation();
        test_jalr();
        test_alias();
        test_gating();
        test_back_to_back();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
